axi_stream_window_tx: RTL

Transmit-side counterpart of the sliding-window front end: accepts the per-pixel results produced downstream of the 3x3 window (an 8-bit pixel plus a `validpixel` strobe, no backpressure of its own) and re-emits them as an AXI4-Stream master with frame markers. It sits at the output of the filter pipeline and discards the window warm-up pixels. It regenerates `tuser` (start of frame) and `tlast` (end of line) from row/column counters. A small FIFO absorbs sink backpressure, and an almost-full flag tells the pipeline to stall its `validpixel` source.

---
 rtl/axi_stream_window_tx.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/axi_stream_window_tx.sv
// Re-emits filtered pixels as an AXI4-Stream master: drops warm-up pixels, regenerates
// tuser/tlast from row/column counters, and buffers beats in a small FIFO.
module axi_stream_window_tx #(
  parameter int fifo_depth_g = 16,
  parameter int skip_g       = 0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [7:0]  pixel_i,
  input  logic        validpixel_i,
  input  logic [12:0] xsize_i,
  input  logic [12:0] ysize_i,
  output logic        almost_full_o,
  output logic [7:0]  m_axis_tdata_o,
  output logic        m_axis_tvalid_o,
  input  logic        m_axis_tready_i,
  output logic        m_axis_tlast_o,
  output logic        m_axis_tuser_o,
  output logic        frame_done_o,
  output logic        overflow_o
);

  localparam int AW = $clog2(fifo_depth_g);

  typedef struct packed {
    logic       eof;
    logic       sof;
    logic       eol;
    logic [7:0] data;
  } entry_t;

  entry_t      mem_q [fifo_depth_g];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_d;
  logic [12:0] skip_q, skip_d;
  logic [12:0] col_q, col_d;
  logic [12:0] row_q, row_d;
  logic [12:0] xsize_q, xsize_d;
  logic [12:0] ysize_q, ysize_d;
  logic        almost_full_q, almost_full_d;
  logic        frame_done_q, frame_done_d;
  logic        overflow_q, overflow_d;

  logic        full, empty, pop, push, accept;
  logic        sof, eol, eof;
  logic [12:0] xs, ys;
  entry_t      wr_entry, head;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign pop   = !empty && m_axis_tready_i;

  // A kept pixel advances the geometry even when the FIFO has to drop it.
  assign accept = validpixel_i && (skip_q == 13'd0);
  assign push   = accept && (!full || pop);

  // The first pixel of a frame uses the live sizes; they are latched for the rest.
  assign sof = (col_q == 13'd0) && (row_q == 13'd0);
  assign xs  = sof ? xsize_i : xsize_q;
  assign ys  = sof ? ysize_i : ysize_q;
  assign eol = (col_q == xs);
  assign eof = eol && (row_q == ys);

  assign wr_entry = '{eof: eof, sof: sof, eol: eol, data: pixel_i};
  assign head     = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    skip_d        = skip_q;
    col_d         = col_q;
    row_d         = row_q;
    xsize_d       = xsize_q;
    ysize_d       = ysize_q;
    wr_ptr_d      = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d      = rd_ptr_q + {{AW{1'b0}}, pop};
    count_d       = wr_ptr_d - rd_ptr_d;
    almost_full_d = (count_d >= (AW+1)'(fifo_depth_g - 4));
    frame_done_d  = pop && head.eof;
    overflow_d    = overflow_q || (accept && full && !pop);

    if (validpixel_i && skip_q != 13'd0) begin
      skip_d = skip_q - 13'd1;
    end

    if (accept) begin
      if (sof) begin
        xsize_d = xsize_i;
        ysize_d = ysize_i;
      end
      if (eof) begin
        col_d  = 13'd0;
        row_d  = 13'd0;
        skip_d = 13'(skip_g);
      end else if (eol) begin
        col_d = 13'd0;
        row_d = row_q + 13'd1;
      end else begin
        col_d = col_q + 13'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      skip_q        <= 13'(skip_g);
      col_q         <= '0;
      row_q         <= '0;
      xsize_q       <= '0;
      ysize_q       <= '0;
      almost_full_q <= 1'b0;
      frame_done_q  <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      skip_q        <= skip_d;
      col_q         <= col_d;
      row_q         <= row_d;
      xsize_q       <= xsize_d;
      ysize_q       <= ysize_d;
      almost_full_q <= almost_full_d;
      frame_done_q  <= frame_done_d;
      overflow_q    <= overflow_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers define which
  // entries are live, and the outputs are masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
    end
  end

  assign m_axis_tvalid_o = !empty;
  assign m_axis_tdata_o  = empty ? 8'h00 : head.data;
  assign m_axis_tlast_o  = !empty && head.eol;
  assign m_axis_tuser_o  = !empty && head.sof;
  assign almost_full_o   = almost_full_q;
  assign frame_done_o    = frame_done_q;
  assign overflow_o      = overflow_q;

endmodule
